// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg -- shared definitions for the common data bus arbiter.
//
// Holds the project-wide constants normally found in const.v:
//   ROB_WIDTH_BIT  width of a reorder-buffer index
//   CDB_SRC_ALU    cdb_src encoding for ALU results (0)
//   CDB_SRC_LSB    cdb_src encoding for LSB load results (1)
// It also defines the queued entry type and the local names for the source
// encodings. No ports; imported by cdb_fifo and cdb_arbiter.

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

`ifndef CDB_SRC_ALU
`define CDB_SRC_ALU 1'b0
`endif

`ifndef CDB_SRC_LSB
`define CDB_SRC_LSB 1'b1
`endif

package cdb_arbiter_pkg;

    localparam int ROB_W = `ROB_WIDTH_BIT;

    localparam logic SRC_ALU = `CDB_SRC_ALU;
    localparam logic SRC_LSB = `CDB_SRC_LSB;

    // One queued broadcast request.
    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo -- per-source request queue for the CDB arbiter.
//
// Ports:
//   clk_in  clock, rising edge
//   rst_in  asynchronous active-high reset (pointers and count to 0)
//   push    write wdata at the tail this edge
//   pop     retire the head entry this edge
//   clear   flush; wins over push and pop in the same edge
//   wdata   entry to enqueue
//   count   registered occupancy, 0..DEPTH
//   head    entry at the read pointer (meaningful only when count != 0)
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// The caller guarantees push only when not full and pop only when not empty.

module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  cdb_entry_t       wdata,
    output logic [CNT_W-1:0] count,
    output cdb_entry_t       head
);

    localparam int PTR_W = $clog2(DEPTH);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is never reset.
    always_ff @(posedge clk_in) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- merges ALU and LSB results onto the common data bus.
//
// Each source has its own cdb_fifo. Every unpaused, unflushed edge pops at
// most one entry and registers it onto the cdb_* outputs for one cycle.
//
// Ports:
//   clk_in, rst_in                       clock / async active-high reset
//   rdy_in                               global pause when low
//   clear_in                             flush both queues (misprediction)
//   alu_valid, alu_rob_id, alu_value     ALU request, alu_ready back
//   lsb_valid, lsb_rob_id, lsb_value     LSB request, lsb_ready back
//   cdb_valid, cdb_rob_id, cdb_value,    registered broadcast;
//   cdb_src                              cdb_src 0 = ALU, 1 = LSB
//
// Build option CDB_ROUND_ROBIN_EN: when defined, alternate sources when both
// queues hold entries (tracked in last_grant). When undefined, the LSB queue
// always has priority and no grant history is kept.

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear_in,
    input  logic                      alu_valid,
    input  logic [`ROB_WIDTH_BIT-1:0] alu_rob_id,
    input  logic [31:0]               alu_value,
    output logic                      alu_ready,
    input  logic                      lsb_valid,
    input  logic [`ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,
    output logic                      lsb_ready,
    output logic                      cdb_valid,
    output logic [`ROB_WIDTH_BIT-1:0] cdb_rob_id,
    output logic [31:0]               cdb_value,
    output logic                      cdb_src
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0] alu_count;
    logic [CNT_W-1:0] lsb_count;
    cdb_entry_t       alu_wdata;
    cdb_entry_t       lsb_wdata;
    cdb_entry_t       alu_head;
    cdb_entry_t       lsb_head;
    logic             advance;
    logic             alu_push;
    logic             lsb_push;
    logic             alu_pop;
    logic             lsb_pop;
    logic             grant_lsb;

    cdb_entry_t       bcast_p1;
    logic             src_p1;
    logic             vld_p1;

    // Ready depends only on registered counts and global controls, so a
    // pop in the same edge never frees a slot combinationally.
    assign advance   = rdy_in && !clear_in;
    assign alu_ready = advance && (alu_count < DEPTH_C);
    assign lsb_ready = advance && (lsb_count < DEPTH_C);
    assign alu_push  = alu_valid && alu_ready;
    assign lsb_push  = lsb_valid && lsb_ready;

    assign alu_wdata = '{rob_id: alu_rob_id, value: alu_value};
    assign lsb_wdata = '{rob_id: lsb_rob_id, value: lsb_value};

`ifdef CDB_ROUND_ROBIN_EN
    logic last_grant;

    // With both queues occupied, serve the source that did not win last.
    assign grant_lsb = (lsb_count != '0) &&
                       ((alu_count == '0) || (last_grant == SRC_ALU));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant <= SRC_LSB;
        end else if (alu_pop || lsb_pop) begin
            last_grant <= lsb_pop ? SRC_LSB : SRC_ALU;
        end
    end
`else
    assign grant_lsb = (lsb_count != '0);
`endif

    assign lsb_pop = advance && grant_lsb;
    assign alu_pop = advance && !grant_lsb && (alu_count != '0);

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_alu_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (alu_push),
        .pop    (alu_pop),
        .clear  (clear_in),
        .wdata  (alu_wdata),
        .count  (alu_count),
        .head   (alu_head)
    );

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_lsb_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (lsb_push),
        .pop    (lsb_pop),
        .clear  (clear_in),
        .wdata  (lsb_wdata),
        .count  (lsb_count),
        .head   (lsb_head)
    );

    // ---- stage p1: registered broadcast; payload holds when idle ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p1   <= 1'b0;
            src_p1   <= SRC_ALU;
            bcast_p1 <= '0;
        end else if (alu_pop || lsb_pop) begin
            vld_p1   <= 1'b1;
            src_p1   <= lsb_pop ? SRC_LSB : SRC_ALU;
            bcast_p1 <= lsb_pop ? lsb_head : alu_head;
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    assign cdb_valid  = vld_p1;
    assign cdb_src    = src_p1;
    assign cdb_rob_id = bcast_p1.rob_id;
    assign cdb_value  = bcast_p1.value;

endmodule
